// File: rtl/control_filtro_recursivo.sv
// Three-cycle sequencer for a first-order IIR filter, time-sharing one external
// multiplier and one saturating adder; holds the x[n-1]/y[n-1] filter state.
module control_filtro_recursivo #(
    parameter int Width = 22
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_valid,
    input  logic [Width-1:0] x_in,
    input  logic [Width-1:0] b0,
    input  logic [Width-1:0] b1,
    input  logic [Width-1:0] a1,
    input  logic             clr_state,
    input  logic             clr_ovr,
    output logic [Width-1:0] mul_a,
    output logic [Width-1:0] mul_b,
    input  logic [Width-1:0] mul_y,
    output logic [Width-1:0] add_a,
    output logic [Width-1:0] add_b,
    input  logic [Width-1:0] add_y,
    output logic [Width-1:0] y_out,
    output logic             y_valid,
    output logic             busy,
    output logic             overrun
);

    // Handshake: sample_valid is a one-cycle strobe with no ready; a strobe
    // seen outside IDLE is dropped and recorded in the sticky overrun flag.
    typedef enum logic [1:0] {IDLE, P0, P1, P2} state_t;

    state_t           state;
    logic [Width-1:0] acc, x1, y1, xr, cb0, cb1, ca1;

    assign busy = (state != IDLE);

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        add_a = '0;
        add_b = '0;
        case (state)
            P0: begin
                mul_a = xr;
                mul_b = cb0;
            end
            P1: begin
                mul_a = x1;
                mul_b = cb1;
                add_a = acc;
                add_b = mul_y;
            end
            P2: begin
                mul_a = y1;
                mul_b = ca1;
                add_a = acc;
                add_b = mul_y;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            x1      <= '0;
            y1      <= '0;
            xr      <= '0;
            cb0     <= '0;
            cb1     <= '0;
            ca1     <= '0;
            y_out   <= '0;
            y_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            y_valid <= 1'b0;
            if (clr_ovr)
                overrun <= 1'b0;
            if (clr_state) begin
                // Abort: the strobe in this cycle is dropped without flagging overrun.
                state <= IDLE;
                acc   <= '0;
                x1    <= '0;
                y1    <= '0;
            end else begin
                if (sample_valid && state != IDLE)
                    overrun <= 1'b1;
                case (state)
                    IDLE: begin
                        if (sample_valid) begin
                            xr    <= x_in;
                            cb0   <= b0;
                            cb1   <= b1;
                            ca1   <= a1;
                            state <= P0;
                        end
                    end
                    P0: begin
                        acc   <= mul_y;
                        state <= P1;
                    end
                    P1: begin
                        acc   <= add_y;
                        state <= P2;
                    end
                    P2: begin
                        y_out   <= add_y;
                        y1      <= add_y;
                        x1      <= xr;
                        y_valid <= 1'b1;
                        state   <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_control_filtro_recursivo.sv
// Directed bench for control_filtro_recursivo with behavioural models of the
// external Q11 multiplier and symmetric saturating adder.
module tb_control_filtro_recursivo;

    localparam int W = 22;
    localparam longint MAXV = (64'sd1 <<< (W - 1)) - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sample_valid;
    logic [W-1:0] x_in, b0, b1, a1;
    logic         clr_state, clr_ovr;
    logic [W-1:0] mul_a, mul_b, mul_y, add_a, add_b, add_y;
    logic [W-1:0] y_out;
    logic         y_valid, busy, overrun;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    control_filtro_recursivo #(.Width(W)) dut (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .x_in(x_in),
        .b0(b0), .b1(b1), .a1(a1), .clr_state(clr_state), .clr_ovr(clr_ovr),
        .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y),
        .add_a(add_a), .add_b(add_b), .add_y(add_y),
        .y_out(y_out), .y_valid(y_valid), .busy(busy), .overrun(overrun)
    );

    function automatic logic [W-1:0] sat(input longint v);
        longint r;
        r = v;
        if (r > MAXV) r = MAXV;
        if (r < -MAXV) r = -MAXV;
        return r[W-1:0];
    endfunction

    function automatic logic [W-1:0] mul_model(input logic [W-1:0] a, input logic [W-1:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return sat(p >>> 11);
    endfunction

    function automatic logic [W-1:0] add_model(input logic [W-1:0] a, input logic [W-1:0] b);
        return sat(longint'($signed(a)) + longint'($signed(b)));
    endfunction

    assign mul_y = mul_model(mul_a, mul_b);
    assign add_y = add_model(add_a, add_b);

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clr_state = 1'b1;
        clr_ovr   = 1'b1;
        tick();
        clr_state = 1'b0;
        clr_ovr   = 1'b0;
    endtask

    // Called #1 after a rising edge with the controller idle; returns clocks to y_valid.
    task automatic run_sample(input logic [W-1:0] x, input logic [W-1:0] cb0,
                              input logic [W-1:0] cb1, input logic [W-1:0] ca1,
                              output int lat);
        x_in = x; b0 = cb0; b1 = cb1; a1 = ca1;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        lat = 0;
        while (!y_valid && lat < 10) begin
            tick();
            lat++;
        end
    endtask

    typedef struct {
        bit           clr;
        logic [W-1:0] x, cb0, cb1, ca1, y;
        string        name;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input bit clr, input int x, input int cb0, input int cb1,
                           input int ca1, input int y, input string name);
        vec_t v;
        v.clr = clr; v.x = x; v.cb0 = cb0; v.cb1 = cb1; v.ca1 = ca1; v.y = y; v.name = name;
        vq.push_back(v);
    endtask

    initial begin
        int lat, pulses, first_c;
        int pulse_c[$];

        rst_n = 1'b0; sample_valid = 1'b0; x_in = '0; b0 = '0; b1 = '0; a1 = '0;
        clr_state = 1'b0; clr_ovr = 1'b0;
        repeat (3) tick();
        check("reset_y_out", y_out, 0);
        check("reset_y_valid", {21'd0, y_valid}, 0);
        check("reset_busy", {21'd0, busy}, 0);
        check("reset_overrun", {21'd0, overrun}, 0);
        check("reset_mul_a", mul_a, 0);
        check("reset_add_a", add_a, 0);
        rst_n = 1'b1;
        tick();

        add_vec(1, 2048, 2048, 0, 1024, 2048, "impulse0");
        add_vec(0, 0, 2048, 0, 1024, 1024, "impulse1");
        add_vec(0, 0, 2048, 0, 1024, 512, "impulse2");
        add_vec(0, 0, 2048, 0, 1024, 256, "impulse3");
        add_vec(1, 4000, 1024, 1024, 0, 2000, "fir0");
        add_vec(0, 4000, 1024, 1024, 0, 4000, "fir1");
        add_vec(0, 0, 1024, 1024, 0, 2000, "fir2");
        add_vec(1, 1048576, 2048, 0, 2048, 1048576, "satpos0");
        add_vec(0, 1048576, 2048, 0, 2048, 2097151, "satpos1");
        add_vec(0, 1048576, 2048, 0, 2048, 2097151, "satpos2");
        add_vec(1, -1048576, 2048, 0, 2048, -1048576, "satneg0");
        add_vec(0, -1048576, 2048, 0, 2048, -2097151, "satneg1");
        add_vec(0, -1048576, 2048, 0, 2048, -2097151, "satneg2");

        foreach (vq[i]) begin
            if (vq[i].clr) do_clear();
            run_sample(vq[i].x, vq[i].cb0, vq[i].cb1, vq[i].ca1, lat);
            check({vq[i].name, "_latency"}, lat, 3);
            check({vq[i].name, "_y"}, y_out, vq[i].y);
        end
        tick();
        check("y_valid_one_cycle", {21'd0, y_valid}, 0);

        // Reset asserted mid-P1 clears everything immediately.
        x_in = 5; b0 = 2048; b1 = 0; a1 = 0;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        tick();
        check("busy_in_p1", {21'd0, busy}, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_y_out", y_out, 0);
        check("midrst_y_valid", {21'd0, y_valid}, 0);
        check("midrst_busy", {21'd0, busy}, 0);
        check("midrst_overrun", {21'd0, overrun}, 0);
        check("midrst_mul_a", mul_a, 0);
        check("midrst_mul_b", mul_b, 0);
        check("midrst_add_a", add_a, 0);
        check("midrst_add_b", add_b, 0);
        tick();
        rst_n = 1'b1;
        pulses = 0;
        repeat (5) begin tick(); if (y_valid) pulses++; end
        check("midrst_no_pulse", pulses, 0);

        // Overrun: strobe during P1 is dropped, in-flight result intact.
        do_clear();
        x_in = 500; b0 = 2048; b1 = 0; a1 = 0;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        tick();
        x_in = 9999;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        check("ovr_set", {21'd0, overrun}, 1);
        tick();
        check("ovr_y_valid", {21'd0, y_valid}, 1);
        check("ovr_y", y_out, 500);
        pulses = 0;
        repeat (6) begin tick(); if (y_valid) pulses++; end
        check("ovr_no_extra", pulses, 0);
        check("ovr_sticky", {21'd0, overrun}, 1);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        check("ovr_cleared", {21'd0, overrun}, 0);
        x_in = 700;
        sample_valid = 1'b1;
        tick();
        clr_ovr = 1'b1;
        tick();
        sample_valid = 1'b0;
        clr_ovr = 1'b0;
        check("ovr_set_wins", {21'd0, overrun}, 1);
        lat = 0;
        while (!y_valid && lat < 10) begin tick(); lat++; end
        check("ovr2_y", y_out, 700);

        // sample_valid held high: one result every 4 clocks.
        do_clear();
        x_in = 100; b0 = 2048; b1 = 0; a1 = 0;
        sample_valid = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (y_valid) begin
                pulse_c.push_back(c);
                check("held_y", y_out, 100);
            end
        end
        sample_valid = 1'b0;
        check("held_pulses", pulse_c.size(), 4);
        foreach (pulse_c[k]) check("held_spacing", pulse_c[k], 4 * (k + 1));
        tick();

        // clr_state during P2 aborts and zeroes filter state.
        do_clear();
        run_sample(2048, 2048, 0, 1024, lat);
        check("pre_abort_y", y_out, 2048);
        x_in = 2048;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        tick();
        tick();
        clr_state = 1'b1;
        sample_valid = 1'b1;
        tick();
        clr_state = 1'b0;
        sample_valid = 1'b0;
        check("abort_busy", {21'd0, busy}, 0);
        check("abort_y_valid", {21'd0, y_valid}, 0);
        check("abort_overrun", {21'd0, overrun}, 0);
        check("abort_y_hold", y_out, 2048);
        pulses = 0;
        repeat (5) begin tick(); if (y_valid) pulses++; end
        check("abort_no_pulse", pulses, 0);
        run_sample(2048, 2048, 0, 1024, lat);
        check("post_abort_lat", lat, 3);
        check("post_abort_y", y_out, 2048);
        run_sample(0, 2048, 0, 1024, lat);
        check("post_abort_y1", y_out, 1024);
        first_c = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
